// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
//
// Contents:
//   state_t     - FSM state encoding (3-bit) used by matmul_sequencer
//   MEM_LAT     - read latency of the A/B operand memories, in cycles
//   clog2_min1  - ceil(log2(v)) clamped to at least 1, for sizing
//                 address and index buses when N is small

package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_MAC   = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // The FETCH -> LATCH split exists because of this one-cycle read latency.
  localparam int MEM_LAT = 1;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/matmul_sequencer_idx_counter.sv
// Loop index counter used for the i, j and k loops of the sequencer.
//
// Parameters:
//   WIDTH - counter width
//   MAX   - terminal count; 'last' is high while cnt == MAX
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset, clears the count
//   inc  in   advance the count by one
//   clr  in   return the count to zero (wins over inc)
//   cnt  out  current count
//   last out  count has reached MAX

module idx_counter #(
  parameter int WIDTH = 2,
  parameter int MAX   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             last
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == WIDTH'(MAX));

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for the 8-bit matrix-multiply datapath, computing C = A x B
// for NxN row-major matrices. One C element is produced per inner k loop,
// in row-major order of C, taking 3N+1 cycles each.
//
// Parameters:
//   N  - matrix dimension (N >= 1)
//   AW - A/B/C memory address width
//   IW - i/j/k loop index width
// Ports:
//   clk      in   clock, all state changes on posedge
//   rst      in   synchronous active-high reset, aborts any run
//   start    in   begin a multiplication (only looked at in IDLE)
//   busy     out  high in FETCH/LATCH/MAC/WRITE
//   done     out  one-cycle pulse after the last C element is written
//   a_addr   out  A read address i*N+k (0 outside FETCH/LATCH/MAC)
//   b_addr   out  B read address k*N+j (0 outside FETCH/LATCH/MAC)
//   c_addr   out  C write address i*N+j (0 unless c_we)
//   wr_a     out  load strobe, operand-A register
//   wr_b     out  load strobe, operand-B register
//   acc_clr  out  clear accumulator (first FETCH of each element)
//   acc_en   out  accumulator adds the current product
//   c_we     out  C memory write enable

module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = clog2_min1(N * N),
  parameter int IW = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] a_addr,
  output logic [AW-1:0] b_addr,
  output logic [AW-1:0] c_addr,
  output logic          wr_a,
  output logic          wr_b,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          c_we
);

  localparam logic [AW-1:0] N_A = AW'(N);

  state_t state_q;
  state_t state_d;

  logic [IW-1:0] i_cnt, j_cnt, k_cnt;
  logic          i_last, j_last, k_last;
  logic          i_inc, j_inc, k_inc;
  logic          i_clr, j_clr, k_clr;
  logic          in_operand;

  idx_counter #(.WIDTH(IW), .MAX(N - 1)) u_i_cnt (
    .clk (clk),
    .rst (rst),
    .inc (i_inc),
    .clr (i_clr),
    .cnt (i_cnt),
    .last(i_last)
  );

  idx_counter #(.WIDTH(IW), .MAX(N - 1)) u_j_cnt (
    .clk (clk),
    .rst (rst),
    .inc (j_inc),
    .clr (j_clr),
    .cnt (j_cnt),
    .last(j_last)
  );

  idx_counter #(.WIDTH(IW), .MAX(N - 1)) u_k_cnt (
    .clk (clk),
    .rst (rst),
    .inc (k_inc),
    .clr (k_clr),
    .cnt (k_cnt),
    .last(k_last)
  );

  // Next state and loop-index control. Indices advance at the edge that
  // leaves MAC (k) or WRITE (j, i), so addresses stay stable for the whole
  // FETCH/LATCH/MAC window of a term. The final WRITE also zeroes i and j so
  // the indices are back at zero when the sequencer returns to IDLE.
  always_comb begin
    state_d = state_q;
    i_inc   = 1'b0;
    j_inc   = 1'b0;
    k_inc   = 1'b0;
    i_clr   = 1'b0;
    j_clr   = 1'b0;
    k_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          i_clr   = 1'b1;
          j_clr   = 1'b1;
          k_clr   = 1'b1;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_MAC;
      ST_MAC: begin
        if (k_last) begin
          k_clr   = 1'b1;
          state_d = ST_WRITE;
        end else begin
          k_inc   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_WRITE: begin
        if (!j_last) begin
          j_inc   = 1'b1;
          state_d = ST_FETCH;
        end else if (!i_last) begin
          j_clr   = 1'b1;
          i_inc   = 1'b1;
          state_d = ST_FETCH;
        end else begin
          j_clr   = 1'b1;
          i_clr   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore outputs: decoded only from the state flop and the index flops,
  // so a reset clears every output on the following cycle.
  assign in_operand = (state_q == ST_FETCH) || (state_q == ST_LATCH) ||
                      (state_q == ST_MAC);

  assign busy    = in_operand || (state_q == ST_WRITE);
  assign done    = (state_q == ST_DONE);
  assign wr_a    = (state_q == ST_LATCH);
  assign wr_b    = (state_q == ST_LATCH);
  assign acc_clr = (state_q == ST_FETCH) && (k_cnt == '0);
  assign acc_en  = (state_q == ST_MAC);
  assign c_we    = (state_q == ST_WRITE);

  // Products fit in AW bits because every index is at most N-1.
  assign a_addr = in_operand ? (AW'(i_cnt) * N_A + AW'(k_cnt)) : '0;
  assign b_addr = in_operand ? (AW'(k_cnt) * N_A + AW'(j_cnt)) : '0;
  assign c_addr = c_we ? (AW'(i_cnt) * N_A + AW'(j_cnt)) : '0;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer. Two instances (N=2 and N=3) share clock
// and reset; 'sel' steers start to one of them and selects which one drives
// the observed signals. A behavioural operand memory / register /
// accumulator / C memory hangs off the observed signals, and the expected C
// elements from a direct matrix product are queued at start and popped on
// each c_we.

module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  logic sel;

  logic       start2, start3;
  logic       busy2, done2, wr_a2, wr_b2, acc_clr2, acc_en2, c_we2;
  logic [1:0] a_addr2, b_addr2, c_addr2;
  logic       busy3, done3, wr_a3, wr_b3, acc_clr3, acc_en3, c_we3;
  logic [3:0] a_addr3, b_addr3, c_addr3;

  assign start2 = start & ~sel;
  assign start3 = start & sel;

  matmul_sequencer #(.N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .a_addr(a_addr2), .b_addr(b_addr2), .c_addr(c_addr2),
    .wr_a(wr_a2), .wr_b(wr_b2), .acc_clr(acc_clr2), .acc_en(acc_en2),
    .c_we(c_we2)
  );

  matmul_sequencer #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .done(done3),
    .a_addr(a_addr3), .b_addr(b_addr3), .c_addr(c_addr3),
    .wr_a(wr_a3), .wr_b(wr_b3), .acc_clr(acc_clr3), .acc_en(acc_en3),
    .c_we(c_we3)
  );

  logic       busy_m, done_m, wr_a_m, wr_b_m, acc_clr_m, acc_en_m, c_we_m;
  logic [3:0] a_addr_m, b_addr_m, c_addr_m;

  assign busy_m    = sel ? busy3    : busy2;
  assign done_m    = sel ? done3    : done2;
  assign wr_a_m    = sel ? wr_a3    : wr_a2;
  assign wr_b_m    = sel ? wr_b3    : wr_b2;
  assign acc_clr_m = sel ? acc_clr3 : acc_clr2;
  assign acc_en_m  = sel ? acc_en3  : acc_en2;
  assign c_we_m    = sel ? c_we3    : c_we2;
  assign a_addr_m  = sel ? a_addr3  : {2'b00, a_addr2};
  assign b_addr_m  = sel ? b_addr3  : {2'b00, b_addr2};
  assign c_addr_m  = sel ? c_addr3  : {2'b00, c_addr2};

  // Behavioural datapath: 1-cycle-latency A/B memories, operand registers,
  // accumulator and C memory.
  int          a_mem [16];
  int          b_mem [16];
  logic [19:0] c_mem [16];
  logic [7:0]  a_rd, b_rd, op_a, op_b;
  logic [19:0] acc_m;

  always @(posedge clk) begin
    a_rd <= 8'(a_mem[a_addr_m]);
    b_rd <= 8'(b_mem[b_addr_m]);
    if (wr_a_m) op_a <= a_rd;
    if (wr_b_m) op_b <= b_rd;
    if (acc_clr_m) acc_m <= '0;
    else if (acc_en_m) acc_m <= acc_m + 20'(op_a) * 20'(op_b);
    if (c_we_m) c_mem[c_addr_m] <= acc_m;
  end

  int errors = 0;
  int checks = 0;
  int exp_addr [$];
  int exp_val  [$];
  int fa_q [$];
  int fb_q [$];
  int ca_q [$];
  int clr_n, en_n;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference product, queued in row-major order of C.
  task automatic push_expected(input int n);
    int s;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += (a_mem[i*n+k] & 255) * (b_mem[k*n+j] & 255);
        exp_addr.push_back(i * n + j);
        exp_val.push_back(s);
      end
    end
  endtask

  task automatic launch(input int n, input bit hold);
    push_expected(n);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Watches one run cycle by cycle from the first FETCH (c=1). Stops at the
  // done pulse, or asserts rst at cycle abort_c. start is pulsed for one
  // cycle at mid_c when mid_c > 0.
  task automatic monitor_run(input int n, input int abort_c, input int mid_c,
                             output bit aborted);
    int c, we_n, viol, expa, expv, done_c;
    c = 0; we_n = 0; viol = 0; done_c = -1; aborted = 1'b0;
    clr_n = 0; en_n = 0;
    fa_q.delete(); fb_q.delete(); ca_q.delete();
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        checks++;
        if (busy_m !== 1'b1) begin
          errors++;
          $display("[TB] FAIL busy_after_start: got %b want 1", busy_m);
        end
      end
      if (mid_c > 0 && c == mid_c) start = 1'b1;
      if (mid_c > 0 && c == mid_c + 1) start = 1'b0;
      if (acc_clr_m && acc_en_m) viol++;
      if ((wr_a_m || wr_b_m) && acc_en_m) viol++;
      if (!c_we_m && c_addr_m !== 4'd0) viol++;
      if (acc_clr_m) clr_n++;
      if (acc_en_m) en_n++;
      if (busy_m && !wr_a_m && !acc_en_m && !c_we_m) begin
        fa_q.push_back(int'(a_addr_m));
        fb_q.push_back(int'(b_addr_m));
      end
      if (c_we_m) begin
        we_n++;
        ca_q.push_back(int'(c_addr_m));
        checks++;
        if (exp_addr.size() == 0) begin
          errors++;
          $display("[TB] FAIL extra_write: got c_addr %0d want no write", c_addr_m);
        end else begin
          expa = exp_addr.pop_front();
          expv = exp_val.pop_front();
          if (c_addr_m !== 4'(expa)) begin
            errors++;
            $display("[TB] FAIL c_addr: got %0d want %0d", c_addr_m, expa);
          end
          checks++;
          if (acc_m !== 20'(expv)) begin
            errors++;
            $display("[TB] FAIL c_value@%0d: got %0d want %0d", expa, acc_m, expv);
          end
        end
      end
      if (done_m) begin
        done_c = c;
        break;
      end
      if (c == abort_c) begin
        rst = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      checks++;
      if (done_c != n * n * (3 * n + 1) + 1) begin
        errors++;
        $display("[TB] FAIL done_cycle: got %0d want %0d", done_c, n * n * (3 * n + 1) + 1);
      end
      checks++;
      if (we_n != n * n) begin
        errors++;
        $display("[TB] FAIL c_we_count: got %0d want %0d", we_n, n * n);
      end
      checks++;
      if (clr_n != n * n) begin
        errors++;
        $display("[TB] FAIL acc_clr_count: got %0d want %0d", clr_n, n * n);
      end
      checks++;
      if (en_n != n * n * n) begin
        errors++;
        $display("[TB] FAIL acc_en_count: got %0d want %0d", en_n, n * n * n);
      end
      checks++;
      if (exp_addr.size() != 0) begin
        errors++;
        $display("[TB] FAIL missing_writes: got %0d pending want 0", exp_addr.size());
      end
      checks++;
      if (viol != 0) begin
        errors++;
        $display("[TB] FAIL strobe_rules: got %0d violations want 0", viol);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({busy_m, done_m, wr_a_m, wr_b_m, acc_clr_m, acc_en_m, c_we_m} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL %s_ctrl: got %b want 0000000", tag,
               {busy_m, done_m, wr_a_m, wr_b_m, acc_clr_m, acc_en_m, c_we_m});
    end
    checks++;
    if ({a_addr_m, b_addr_m, c_addr_m} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL %s_addr: got %h want 000", tag, {a_addr_m, b_addr_m, c_addr_m});
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = int'($urandom_range(0, 255));
      b_mem[i] = int'($urandom_range(0, 255));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      #1;
      check_all_zero(s == 1 ? "reset_n3" : "reset_n2");
    end
    rst = 1'b0;
  endtask

  task automatic test_n2_identity();
    bit ab;
    int want [4] = '{1, 2, 3, 4};
    sel = 1'b0;
    a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
    b_mem[0] = 1; b_mem[1] = 0; b_mem[2] = 0; b_mem[3] = 1;
    @(negedge clk);
    check_all_zero("idle_before_n2");
    launch(2, 1'b0);
    monitor_run(2, 0, 0, ab);
    for (int e = 0; e < 4; e++) begin
      checks++;
      if (c_mem[e] !== 20'(want[e])) begin
        errors++;
        $display("[TB] FAIL c_mem_identity[%0d]: got %0d want %0d", e, c_mem[e], want[e]);
      end
    end
  endtask

  task automatic test_n3_const_and_trace();
    bit ab;
    int ea [3] = '{3, 4, 5};
    int eb [3] = '{2, 5, 8};
    int got;
    sel = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_mem[i] = 2;
      b_mem[i] = 3;
    end
    @(negedge clk);
    launch(3, 1'b0);
    monitor_run(3, 0, 0, ab);
    for (int k = 0; k < 3; k++) begin
      got = (fa_q.size() > 15 + k) ? fa_q[15 + k] : -1;
      checks++;
      if (got != ea[k]) begin
        errors++;
        $display("[TB] FAIL trace_a_addr[%0d]: got %0d want %0d", k, got, ea[k]);
      end
      got = (fb_q.size() > 15 + k) ? fb_q[15 + k] : -1;
      checks++;
      if (got != eb[k]) begin
        errors++;
        $display("[TB] FAIL trace_b_addr[%0d]: got %0d want %0d", k, got, eb[k]);
      end
    end
    got = (ca_q.size() > 5) ? ca_q[5] : -1;
    checks++;
    if (got != 5) begin
      errors++;
      $display("[TB] FAIL trace_c_addr: got %0d want 5", got);
    end
  endtask

  task automatic test_start_ignored();
    bit ab;
    int bad;
    sel = 1'b0;
    fill_random();
    @(negedge clk);
    launch(2, 1'b0);
    monitor_run(2, 0, 10, ab);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      if (busy_m || done_m) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL start_in_done: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    bit ab;
    sel = 1'b0;
    fill_random();
    @(negedge clk);
    launch(2, 1'b1);
    monitor_run(2, 0, 0, ab);
    push_expected(2);
    @(negedge clk);
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_between_runs: got busy=%b done=%b want 0 0", busy_m, done_m);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    monitor_run(2, 0, 0, ab);
  endtask

  task automatic test_reset_mid();
    bit ab;
    int n;
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      n = (s == 1) ? 3 : 2;
      fill_random();
      @(negedge clk);
      launch(n, 1'b0);
      monitor_run(n, (s == 1) ? 13 : 10, 0, ab);
      checks++;
      if (ab !== 1'b1) begin
        errors++;
        $display("[TB] FAIL abort_reached: got %b want 1", ab);
      end
      @(negedge clk);
      check_all_zero(s == 1 ? "midrst_n3" : "midrst_n2");
      rst = 1'b0;
      exp_addr.delete();
      exp_val.delete();
      @(negedge clk);
      launch(n, 1'b0);
      monitor_run(n, 0, 0, ab);
    end
  endtask

  initial begin
    test_reset();
    test_n2_identity();
    test_n3_const_and_trace();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
